// File: rtl/adc_remap_sched.sv
// adc_remap_sched
// Controller for the adc_remap channel-reversal stage. A software request to
// change the remap mode is applied only at a frame boundary. While the mode is
// switching, the controller holds off upstream, lets the remap pipeline drain,
// flips remap_en, and waits out the remap_en synchroniser. As a result no frame
// is ever output in mixed order.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   cfg_remap_en  requested remap mode, sampled when cfg_apply is high
//   cfg_apply     one-cycle request to apply cfg_remap_en
//   s_vld, s_eof  upstream beat valid / last beat of frame
//   s_rdy         upstream may transfer (combinational from state and frame_act)
//   map_ivld      accepted beat (s_vld & s_rdy), drives adc_remap.map_ivld
//   remap_en      registered remap mode, drives adc_remap.remap_en
//   cfg_busy      a request is in progress
//   cfg_done      one-cycle pulse: request completed, or was a no-op
//   cfg_err       one-cycle pulse: request dropped because the frame never ended
//   frm_cnt       count of accepted EOF beats, wraps to zero
module adc_remap_sched #(
  parameter int unsigned DRAIN_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned TMO_W      = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_remap_en,
  input  logic             cfg_apply,
  input  logic             s_vld,
  input  logic             s_eof,
  output logic             s_rdy,
  output logic             map_ivld,
  output logic             remap_en,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] frm_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, DRAIN, SETTLE} state_e;

  localparam int unsigned PH_MAX = (DRAIN_CYC > SETTLE_CYC) ? DRAIN_CYC : SETTLE_CYC;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] DRAIN_LAST  = PH_W'(DRAIN_CYC - 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
  // The counter is cleared on entry to ARMED. It therefore holds 2**TMO_W-2 in
  // the (2**TMO_W-1)-th ARMED cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_e           state_q, state_d;
  logic             target_q, target_d;
  logic             remap_en_q, remap_en_d;
  logic             frame_act_q, frame_act_d;
  logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             acc;

  always_comb begin
    unique case (state_q)
      IDLE:    s_rdy = 1'b1;
      ARMED:   s_rdy = frame_act_q;
      default: s_rdy = 1'b0;
    endcase

    acc = s_vld & s_rdy;

    frame_act_d = frame_act_q;
    if (acc) frame_act_d = ~s_eof;
    frm_cnt_d = frm_cnt_q + CNT_W'(acc & s_eof);

    state_d    = state_q;
    target_d   = target_q;
    remap_en_d = remap_en_q;
    tmo_d      = tmo_q;
    ph_d       = ph_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_apply) begin
          if (cfg_remap_en == remap_en_q) begin
            done_d = 1'b1;
          end else begin
            target_d = cfg_remap_en;
            tmo_d    = '0;
            state_d  = ARMED;
          end
        end
      end
      ARMED: begin
        // In ARMED, s_rdy equals frame_act_q. frame_act_d is therefore low only
        // when no frame was open, or when the EOF beat is accepted in this
        // cycle. In the EOF case upstream closes on the very next cycle.
        if (!frame_act_d) begin
          state_d = DRAIN;
          ph_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DRAIN: begin
        if (ph_q == DRAIN_LAST) begin
          state_d    = SETTLE;
          ph_d       = '0;
          remap_en_d = target_q;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      SETTLE: begin
        if (ph_q == SETTLE_LAST) begin
          state_d = IDLE;
          ph_d    = '0;
          done_d  = 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      target_q    <= 1'b0;
      remap_en_q  <= 1'b0;
      frame_act_q <= 1'b0;
      frm_cnt_q   <= '0;
      tmo_q       <= '0;
      ph_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      remap_en_q  <= remap_en_d;
      frame_act_q <= frame_act_d;
      frm_cnt_q   <= frm_cnt_d;
      tmo_q       <= tmo_d;
      ph_q        <= ph_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign map_ivld = acc;
  assign remap_en = remap_en_q;
  assign cfg_busy = (state_q != IDLE);
  assign cfg_done = done_q;
  assign cfg_err  = err_q;
  assign frm_cnt  = frm_cnt_q;

endmodule
